sweep_amplitude_meter: RTL and testbench

- Sits directly downstream of the DDS sweep generator, on the sampled response of the device under test.
- On each frequency-step strobe it discards a settling window of samples, then measures min, max and peak-to-peak over a fixed sample window.
- Presents one result per frequency point on a valid/ready port to the sweep result logger / FFT control path.

---
 rtl/sweep_amplitude_meter.sv | 151 +++++++++++++++
 tb/tb_sweep_amplitude_meter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_amplitude_meter.sv
// Per-frequency-point amplitude meter: after each new_freq strobe it drops a settling
// window, then reports max/min/peak-to-peak over a fixed window on a valid/ready port.
module sweep_amplitude_meter #(
    parameter int DATA_W   = 12,
    parameter int IDX_W    = 6,
    parameter int SETTLE_N = 1024,
    parameter int MEAS_N   = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_freq,
    input  logic [IDX_W-1:0]  freq_idx,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_idx,
    output logic [DATA_W-1:0] res_max,
    output logic [DATA_W-1:0] res_min,
    output logic [DATA_W-1:0] res_pp,
    output logic              busy,
    output logic              overrun
);

    localparam int MAX_N = (SETTLE_N > MEAS_N) ? SETTLE_N : MEAS_N;
    localparam int CNT_W = $clog2(MAX_N + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_N - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_N - 1);

    // state    | meaning
    // S_IDLE   | no point in progress, samples ignored
    // S_SETTLE | discarding settling samples of the current point
    // S_MEASURE| accumulating max/min over the measurement window
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_cur_idx;
    logic [DATA_W-1:0] r_run_max;
    logic [DATA_W-1:0] r_run_min;
    logic              r_busy;

    logic              r_res_valid;
    logic [IDX_W-1:0]  r_res_idx;
    logic [DATA_W-1:0] r_res_max;
    logic [DATA_W-1:0] r_res_min;
    logic [DATA_W-1:0] r_res_pp;
    logic              r_overrun;

    logic              w_beat;
    logic              w_settle_beat;
    logic              w_meas_beat;
    logic              w_complete;
    logic              w_load;
    logic [DATA_W-1:0] w_nxt_max;
    logic [DATA_W-1:0] w_nxt_min;

    // A sample coinciding with new_freq belongs to neither the old nor the new point.
    assign w_beat        = sample_valid & ~new_freq;
    assign w_settle_beat = (r_state == S_SETTLE) & w_beat;
    assign w_meas_beat   = (r_state == S_MEASURE) & w_beat;
    assign w_complete    = w_meas_beat & (r_cnt == MEAS_LAST);
    assign w_load        = w_complete & (~r_res_valid | res_ready);

    assign w_nxt_max = (sample > r_run_max) ? sample : r_run_max;
    assign w_nxt_min = (sample < r_run_min) ? sample : r_run_min;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cur_idx <= '0;
            r_run_max <= '0;
            r_run_min <= '1;
            r_busy    <= 1'b0;
        end else if (new_freq) begin
            r_state   <= S_SETTLE;
            r_cnt     <= '0;
            r_cur_idx <= freq_idx;
            r_run_max <= '0;
            r_run_min <= '1;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                S_SETTLE: begin
                    if (w_settle_beat) begin
                        if (r_cnt == SETTLE_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_MEASURE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_MEASURE: begin
                    if (w_meas_beat) begin
                        r_run_max <= w_nxt_max;
                        r_run_min <= w_nxt_min;
                        if (w_complete) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A completion may reload the output in the same cycle the old result is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_max   <= '0;
            r_res_min   <= '0;
            r_res_pp    <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_complete & ~w_load;
            if (w_load) begin
                r_res_valid <= 1'b1;
                r_res_idx   <= r_cur_idx;
                r_res_max   <= w_nxt_max;
                r_res_min   <= w_nxt_min;
                r_res_pp    <= w_nxt_max - w_nxt_min;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_idx   = r_res_idx;
    assign res_max   = r_res_max;
    assign res_min   = r_res_min;
    assign res_pp    = r_res_pp;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_sweep_amplitude_meter.sv
// Self-checking bench for sweep_amplitude_meter: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_sweep_amplitude_meter;

    localparam int DATA_W   = 12;
    localparam int IDX_W    = 6;
    localparam int SETTLE_N = 4;
    localparam int MEAS_N   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              new_freq = 1'b0;
    logic [IDX_W-1:0]  freq_idx = '0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample = '0;
    logic              res_ready = 1'b0;
    logic              res_valid;
    logic [IDX_W-1:0]  res_idx;
    logic [DATA_W-1:0] res_max;
    logic [DATA_W-1:0] res_min;
    logic [DATA_W-1:0] res_pp;
    logic              busy;
    logic              overrun;

    int checks = 0;
    int errors = 0;
    int ov_count = 0;

    sweep_amplitude_meter #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .SETTLE_N(SETTLE_N), .MEAS_N(MEAS_N)
    ) dut (
        .clk(clk), .rst(rst), .new_freq(new_freq), .freq_idx(freq_idx),
        .sample_valid(sample_valid), .sample(sample),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
        .res_max(res_max), .res_min(res_min), .res_pp(res_pp),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = waiting, 1 = settling, 2 = measuring.
    int m_phase;
    int m_settled;
    int m_idx;
    int m_win[$];
    int exp_valid, exp_idx, exp_max, exp_min, exp_pp, exp_over, exp_busy;
    int t_max, t_min;
    bit m_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_settled = 0; m_idx = 0; m_win.delete();
            exp_valid = 0; exp_idx = 0; exp_max = 0; exp_min = 0; exp_pp = 0;
            exp_over = 0; exp_busy = 0;
        end else begin
            m_done = 1'b0;
            exp_over = 0;
            if (new_freq) begin
                m_phase = 1; m_settled = 0; m_idx = int'(freq_idx); m_win.delete();
            end else if (sample_valid && m_phase == 1) begin
                m_settled++;
                if (m_settled == SETTLE_N) m_phase = 2;
            end else if (sample_valid && m_phase == 2) begin
                m_win.push_back(int'(sample));
                if (m_win.size() == MEAS_N) begin
                    m_done = 1'b1;
                    m_phase = 0;
                end
            end
            if (m_done) begin
                if (exp_valid == 0 || res_ready) begin
                    t_max = 0; t_min = 4095;
                    foreach (m_win[i]) begin
                        if (m_win[i] > t_max) t_max = m_win[i];
                        if (m_win[i] < t_min) t_min = m_win[i];
                    end
                    exp_valid = 1; exp_idx = m_idx;
                    exp_max = t_max; exp_min = t_min; exp_pp = t_max - t_min;
                end else begin
                    exp_over = 1;
                end
            end else if (exp_valid == 1 && res_ready) begin
                exp_valid = 0;
            end
            exp_busy = (m_phase != 0) ? 1 : 0;
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("res_valid", int'(res_valid), exp_valid);
            chk("busy", int'(busy), exp_busy);
            chk("overrun", int'(overrun), exp_over);
            if (exp_valid == 1) begin
                chk("res_idx", int'(res_idx), exp_idx);
                chk("res_max", int'(res_max), exp_max);
                chk("res_min", int'(res_min), exp_min);
                chk("res_pp", int'(res_pp), exp_pp);
            end
            if (overrun) ov_count++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int idx);
        new_freq = 1'b1; freq_idx = IDX_W'(idx);
        cyc();
        new_freq = 1'b0;
    endtask

    task automatic send(input int v);
        sample_valid = 1'b1; sample = DATA_W'(v);
        cyc();
        sample_valid = 1'b0;
    endtask

    task automatic settle(input bit gaps);
        for (int i = 0; i < SETTLE_N; i++) begin
            send(4095);
            if (gaps) cyc();
        end
    endtask

    task automatic chk_result(input string tag, input int idx, input int mx, input int mn);
        chk({tag, "_valid"}, int'(res_valid), 1);
        chk({tag, "_idx"}, int'(res_idx), idx);
        chk({tag, "_max"}, int'(res_max), mx);
        chk({tag, "_min"}, int'(res_min), mn);
        chk({tag, "_pp"}, int'(res_pp), mx - mn);
        chk({tag, "_model_max"}, exp_max, mx);
        chk({tag, "_model_min"}, exp_min, mn);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        chk("accept_drops_valid", int'(res_valid), 0);
    endtask

    int ov_before;

    initial begin
        cyc(); cyc();
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_idx", int'(res_idx), 0);
        chk("rst_max", int'(res_max), 0);
        chk("rst_min", int'(res_min), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        cyc();

        // Basic point
        strobe(7);
        settle(1'b0);
        for (int i = 1; i <= MEAS_N; i++) begin
            if (i == MEAS_N) chk("basic_pre_valid", int'(res_valid), 0);
            send(100 * i);
        end
        chk_result("basic", 7, 800, 100);
        accept();

        // Gapped sample_valid
        strobe(9);
        settle(1'b1);
        for (int i = 1; i <= MEAS_N; i++) begin
            send(100 * i);
            if (i != MEAS_N) cyc();
        end
        chk_result("gaps", 9, 800, 100);
        accept();

        // Constant input
        strobe(10);
        settle(1'b0);
        for (int i = 0; i < MEAS_N; i++) send(2048);
        chk_result("const", 10, 2048, 2048);
        accept();

        // Restart mid-measurement
        ov_before = ov_count;
        strobe(2);
        settle(1'b0);
        for (int i = 0; i < 5; i++) send(4000);
        strobe(3);
        chk("restart_valid", int'(res_valid), 0);
        settle(1'b0);
        for (int i = 1; i <= MEAS_N; i++) send(10 * i);
        chk_result("restart", 3, 80, 10);
        chk("restart_no_overrun", ov_count - ov_before, 0);
        accept();

        // Backpressure and overrun
        strobe(4);
        settle(1'b0);
        for (int i = 1; i <= MEAS_N; i++) send(i);
        chk_result("bp4", 4, 8, 1);
        ov_before = ov_count;
        strobe(5);
        settle(1'b0);
        for (int i = 1; i <= MEAS_N; i++) send(50 + i);
        chk("bp_overrun_pulse", int'(overrun), 1);
        chk_result("bp_hold", 4, 8, 1);
        cyc();
        chk("bp_overrun_once", int'(overrun), 0);
        chk("bp_overrun_count", ov_count - ov_before, 1);
        accept();

        // Completion coinciding with acceptance of the previous result
        strobe(6);
        settle(1'b0);
        for (int i = 1; i <= MEAS_N; i++) send(300 + i);
        chk_result("sim6", 6, 308, 301);
        strobe(11);
        settle(1'b0);
        for (int i = 1; i < MEAS_N; i++) send(600 + i);
        sample_valid = 1'b1; sample = DATA_W'(900); res_ready = 1'b1;
        cyc();
        sample_valid = 1'b0; res_ready = 1'b0;
        chk_result("sim11", 11, 900, 601);
        chk("sim_no_overrun", int'(overrun), 0);
        accept();

        // Asynchronous reset in the middle of a measurement
        strobe(12);
        settle(1'b0);
        for (int i = 0; i < 3; i++) send(77);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", int'(res_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_idx", int'(res_idx), 0);
        chk("arst_pp", int'(res_pp), 0);
        cyc();
        rst = 1'b1;
        for (int i = 0; i < SETTLE_N + MEAS_N; i++) send(123);
        chk("arst_ignored_valid", int'(res_valid), 0);
        chk("arst_ignored_busy", int'(busy), 0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            new_freq     = ($urandom_range(0, 39) == 0);
            freq_idx     = IDX_W'($urandom_range(1, 50));
            sample_valid = ($urandom_range(0, 9) < 7);
            sample       = DATA_W'($urandom_range(0, 4095));
            res_ready    = ($urandom_range(0, 2) == 0);
            cyc();
        end
        new_freq = 1'b0; sample_valid = 1'b0; res_ready = 1'b0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
